// File: rtl/vec_pkg.sv
// Shared types and sizes for the vector load/store sequencer.
package vec_pkg;

  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int LW    = $clog2(LANES);

  typedef logic [LANES-1:0][DW-1:0] vec_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WB,
    DONE
  } lsu_state_t;

  // Index of the last active lane; a count of 0 or above LANES means all lanes.
  function automatic logic [LW-1:0] last_lane(input logic [4:0] vl);
    if (vl == 5'd0 || int'(vl) > LANES) begin
      return LW'(LANES - 1);
    end
    return LW'(int'(vl) - 1);
  endfunction

endpackage

// File: rtl/vec_lsu_agu.sv
// Lane address generator: base + ((lane * stride) << 2), all modulo 2^AW.
module vec_lsu_agu
  import vec_pkg::*;
(
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] stride,
  input  logic [LW-1:0] lane,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] offset;

  // Product is truncated to AW bits before the word-to-byte shift.
  always_comb begin
    offset = AW'(lane) * stride;
    addr   = base + {offset[AW-3:0], 2'b00};
  end

endmodule

// File: rtl/vec_lsu.sv
// Vector load/store sequencer: serializes up to LANES lanes onto a single-beat
// memory port, gathers load data and writes the whole vector back at once.
module vec_lsu
  import vec_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op_load,
  input  logic [4:0]    vl,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] stride,
  input  vec_t          st_data,
  input  logic [3:0]    dest_reg,
  output logic          busy,
  output logic          done,
  output logic          wb_we,
  output logic [3:0]    wb_addr,
  output vec_t          wb_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  lsu_state_t    state_q;
  logic [LW-1:0] lane_q;
  logic [LW-1:0] last_q;
  logic          op_load_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] stride_q;
  logic [3:0]    dest_q;
  vec_t          snap_q;
  vec_t          buf_q;

  logic [AW-1:0] agu_base;
  logic [AW-1:0] agu_stride;
  logic [LW-1:0] agu_lane;
  logic [AW-1:0] agu_addr;
  vec_t          buf_merged;

  // Address of the next beat to issue: lane 0 of the incoming request while
  // idle (latched values not yet valid), otherwise the lane after the current one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    agu_base   = base_q;
    agu_stride = stride_q;
    agu_lane   = lane_q + LW'(1);
    if (state_q == IDLE) begin
      agu_base   = base_addr;
      agu_stride = stride;
      agu_lane   = '0;
    end
    buf_merged         = buf_q;
    buf_merged[lane_q] = mem_rdata;
  end

  vec_lsu_agu u_agu (
    .base   (agu_base),
    .stride (agu_stride),
    .lane   (agu_lane),
    .addr   (agu_addr)
  );

  // Sequencer FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      last_q    <= '0;
      op_load_q <= 1'b0;
      base_q    <= '0;
      stride_q  <= '0;
      dest_q    <= '0;
      snap_q    <= '0;
      // NOTE: the load buffer is plain flops, so it is reset with everything
      // else; lanes beyond vl must read back as zero from the first operation.
      buf_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register sees the
      // pre-edge values of the others, regardless of statement order.
      case (state_q)
        IDLE: begin
          if (start) begin
            op_load_q <= op_load;
            last_q    <= last_lane(vl);
            base_q    <= base_addr;
            stride_q  <= stride;
            dest_q    <= dest_reg;
            snap_q    <= st_data;
            buf_q     <= '0;
            lane_q    <= '0;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= ~op_load;
            mem_addr  <= agu_addr;
            mem_wdata <= op_load ? '0 : st_data[0];
            state_q   <= REQ;
          end
        end

        REQ: begin
          if (mem_gnt) begin
            if (op_load_q) begin
              mem_req <= 1'b0;
              state_q <= WAIT;
            end else if (lane_q == last_q) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              done    <= 1'b1;
              state_q <= DONE;
            end else begin
              lane_q    <= agu_lane;
              mem_addr  <= agu_addr;
              mem_wdata <= snap_q[agu_lane];
            end
          end
        end

        WAIT: begin
          if (mem_rvalid) begin
            buf_q <= buf_merged;
            if (lane_q == last_q) begin
              wb_we   <= 1'b1;
              wb_addr <= dest_q;
              wb_data <= buf_merged;
              state_q <= WB;
            end else begin
              lane_q   <= agu_lane;
              mem_req  <= 1'b1;
              mem_addr <= agu_addr;
              state_q  <= REQ;
            end
          end
        end

        WB: begin
          wb_we   <= 1'b0;
          done    <= 1'b1;
          state_q <= DONE;
        end

        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_lsu.sv
// Self-checking bench for vec_lsu: directed scenarios plus randomized
// operations against an arithmetic reference model and a reactive memory.
module tb_vec_lsu;
  import vec_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          op_load = 1'b0;
  logic [4:0]    vl = '0;
  logic [31:0]   base_addr = '0;
  logic [31:0]   stride = '0;
  vec_t          st_data = '0;
  logic [3:0]    dest_reg = '0;
  logic          busy, done, wb_we, mem_req, mem_we;
  logic [3:0]    wb_addr;
  vec_t          wb_data;
  logic [31:0]   mem_addr, mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;

  vec_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_load    (op_load),
    .vl         (vl),
    .base_addr  (base_addr),
    .stride     (stride),
    .st_data    (st_data),
    .dest_reg   (dest_reg),
    .busy       (busy),
    .done       (done),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
  typedef struct { int cyc; logic [3:0] addr; vec_t data; } wb_t;

  beat_t beats[$];
  wb_t   wbs[$];
  int    dones[$];

  // Memory responder configuration
  bit          rand_gnt = 0;
  bit          rand_lat = 0;
  bit          noise    = 0;
  int          rv_lat   = 1;
  int          stall_beat = -1;
  int          stall_left = 0;
  logic [31:0] mem_key  = '0;

  bit          pend = 0;
  int          pend_dly = 0;
  logic [31:0] pend_data = '0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  int          unstable = 0;
  vec_t        last_wb = '0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ mem_key;
  endfunction

  function automatic int eff_vl(input logic [4:0] v);
    return (v == 0 || v > 16) ? 16 : int'(v);
  endfunction

  function automatic logic [31:0] lane_addr(input logic [31:0] b, input logic [31:0] s, input int i);
    longint unsigned bl, sl, il, prod;
    bl = b; sl = s; il = i;
    prod = (il * sl) % 64'h1_0000_0000;
    return 32'((bl + 4 * prod) % 64'h1_0000_0000);
  endfunction

  function automatic vec_t exp_wb(input logic [31:0] b, input logic [31:0] s, input int n);
    vec_t v = '0;
    for (int i = 0; i < n; i++) v[i] = mem_word(lane_addr(b, s, i));
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = $urandom;
    return v;
  endfunction

  // ---------------- monitor + memory responder (negedge) ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_we) wbs.push_back('{cyc, wb_addr, wb_data});
      if (done)  dones.push_back(cyc);
      if (mem_req && prev_stall && (mem_addr !== prev_addr || mem_wdata !== prev_wdata))
        unstable++;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (pend) begin
      pend_dly--;
      if (pend_dly <= 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_data;
        pend       = 0;
      end
    end else if (noise && ($urandom % 4 == 0)) begin
      mem_rvalid = 1'b1;
    end
    mem_gnt = 1'b0;
    if (mem_req && !rst) begin
      if (stall_left > 0 && beats.size() == stall_beat) stall_left--;
      else if (rand_gnt && ($urandom % 3 == 0)) mem_gnt = 1'b0;
      else mem_gnt = 1'b1;
    end
    if (mem_gnt) begin
      beats.push_back('{cyc, mem_we, mem_addr, mem_wdata});
      if (!mem_we) begin
        pend      = 1;
        pend_dly  = rand_lat ? 1 + int'($urandom % 3) : rv_lat;
        pend_data = mem_word(mem_addr);
      end
    end
    prev_stall = mem_req && !mem_gnt;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  // ---------------- stimulus helpers ----------------
  task automatic launch(input bit ld, input logic [4:0] v, input logic [31:0] b,
                        input logic [31:0] s, input vec_t d, input logic [3:0] dr,
                        output int t);
    @(negedge clk);
    #1;
    beats.delete(); wbs.delete(); dones.delete(); unstable = 0;
    op_load = ld; vl = v; base_addr = b; stride = s; st_data = d; dest_reg = dr;
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    #1;
    start = 1'b0;
    // Register-file contents move on; the operation must use its snapshot.
    op_load = $urandom; vl = $urandom; base_addr = $urandom; stride = $urandom;
    st_data = rand_vec(); dest_reg = $urandom;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      #1;
      if (dones.size() > 0) ok = 1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: no done within %0d cycles (got %0d, required 1)", tag, budget, dones.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, done, wb_we, mem_req, mem_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b required 00000", {busy, done, wb_we, mem_req, mem_we});
    end
    n_checks++;
    if (wb_addr !== 4'h0 || wb_data !== '0) begin
      n_fail++;
      $display("FAIL reset_wb: got addr %h data %h required 0", wb_addr, wb_data);
    end
    n_checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem: got addr %h wdata %h required 0", mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_full();
    vec_t d;
    int t;
    for (int i = 0; i < LANES; i++) d[i] = 32'(i + 1);
    launch(1'b0, 5'd16, 32'h100, 32'd1, d, 4'h0, t);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL store16_busy: got %b required 1", busy);
    end
    wait_done("store16", 100);
    n_checks++;
    if (beats.size() != 16) begin
      n_fail++;
      $display("FAIL store16_beats: got %0d required 16", beats.size());
    end
    for (int i = 0; i < beats.size(); i++) begin
      n_checks++;
      if (beats[i].we !== 1'b1 || beats[i].addr !== 32'h100 + 32'(4 * i) ||
          beats[i].wdata !== 32'(i + 1) || beats[i].cyc != t + 1 + i) begin
        n_fail++;
        $display("FAIL store16_beat%0d: got we %b addr %h data %h cyc %0d required 1 %h %h %0d",
                 i, beats[i].we, beats[i].addr, beats[i].wdata, beats[i].cyc,
                 32'h100 + 32'(4 * i), i + 1, t + 1 + i);
      end
    end
    n_checks++;
    if (dones.size() == 0 || dones[0] != t + 17) begin
      n_fail++;
      $display("FAIL store16_done: got cyc %0d required %0d", dones.size() ? dones[0] : -1, t + 17);
    end
    n_checks++;
    if (wbs.size() != 0) begin
      n_fail++;
      $display("FAIL store16_wb: got %0d write-backs required 0", wbs.size());
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL store16_busy_done: got %b required 1", busy);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL store16_idle: got busy %b done %b required 0 0", busy, done);
    end
  endtask

  task automatic test_load_full();
    vec_t ew;
    int t;
    mem_key = '0;
    launch(1'b1, 5'd16, 32'h200, 32'd2, rand_vec(), 4'd3, t);
    wait_done("load16", 200);
    n_checks++;
    if (beats.size() != 16) begin
      n_fail++;
      $display("FAIL load16_beats: got %0d required 16", beats.size());
    end
    for (int i = 0; i < beats.size(); i++) begin
      n_checks++;
      if (beats[i].we !== 1'b0 || beats[i].addr !== 32'h200 + 32'(8 * i) ||
          beats[i].wdata !== 32'h0 || beats[i].cyc != t + 1 + 2 * i) begin
        n_fail++;
        $display("FAIL load16_beat%0d: got we %b addr %h data %h cyc %0d required 0 %h 0 %0d",
                 i, beats[i].we, beats[i].addr, beats[i].wdata, beats[i].cyc,
                 32'h200 + 32'(8 * i), t + 1 + 2 * i);
      end
    end
    for (int i = 0; i < LANES; i++) ew[i] = 32'h200 + 32'(8 * i);
    n_checks++;
    if (wbs.size() != 1) begin
      n_fail++;
      $display("FAIL load16_wbcount: got %0d required 1", wbs.size());
    end else begin
      n_checks++;
      if (wbs[0].cyc != t + 33 || wbs[0].addr !== 4'd3) begin
        n_fail++;
        $display("FAIL load16_wbtime: got cyc %0d reg %0d required %0d 3", wbs[0].cyc, wbs[0].addr, t + 33);
      end
      n_checks++;
      if (wbs[0].data !== ew) begin
        n_fail++;
        $display("FAIL load16_wbdata: got %h required %h", wbs[0].data, ew);
      end
    end
    n_checks++;
    if (dones.size() == 0 || dones[0] != t + 34) begin
      n_fail++;
      $display("FAIL load16_done: got cyc %0d required %0d", dones.size() ? dones[0] : -1, t + 34);
    end
    last_wb = ew;
  endtask

  task automatic test_load_short();
    vec_t ew;
    int t;
    launch(1'b1, 5'd4, 32'h0, 32'd1, rand_vec(), 4'd5, t);
    wait_done("load4", 100);
    ew = '0;
    ew[0] = 32'h0; ew[1] = 32'h4; ew[2] = 32'h8; ew[3] = 32'hC;
    n_checks++;
    if (beats.size() != 4) begin
      n_fail++;
      $display("FAIL load4_beats: got %0d required 4", beats.size());
    end
    n_checks++;
    if (wbs.size() != 1 || wbs[0].data !== ew || wbs[0].addr !== 4'd5) begin
      n_fail++;
      $display("FAIL load4_wb: got count %0d data %h required 1 %h",
               wbs.size(), wbs.size() ? wbs[0].data : '0, ew);
    end
    launch(1'b1, 5'd0, 32'h40, 32'd3, rand_vec(), 4'd9, t);
    wait_done("load_vl0", 200);
    ew = exp_wb(32'h40, 32'd3, 16);
    n_checks++;
    if (beats.size() != 16) begin
      n_fail++;
      $display("FAIL load_vl0_beats: got %0d required 16", beats.size());
    end
    n_checks++;
    if (wbs.size() != 1 || wbs[0].data !== ew || wbs[0].addr !== 4'd9) begin
      n_fail++;
      $display("FAIL load_vl0_wb: got count %0d data %h required 1 %h",
               wbs.size(), wbs.size() ? wbs[0].data : '0, ew);
    end
    last_wb = ew;
  endtask

  task automatic test_stall();
    vec_t d = rand_vec();
    int t;
    bit seen = 0;
    stall_beat = 5;
    stall_left = 3;
    launch(1'b0, 5'd16, 32'h1000, 32'd1, d, 4'h0, t);
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (beats.size() >= 5) seen = 1;
    end
    start = 1'b1;
    op_load = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_done("stall", 100);
    stall_beat = -1;
    n_checks++;
    if (beats.size() != 16) begin
      n_fail++;
      $display("FAIL stall_beats: got %0d required 16", beats.size());
    end
    for (int i = 0; i < beats.size(); i++) begin
      n_checks++;
      if (beats[i].we !== 1'b1 || beats[i].addr !== lane_addr(32'h1000, 32'd1, i) ||
          beats[i].wdata !== d[i]) begin
        n_fail++;
        $display("FAIL stall_beat%0d: got we %b addr %h data %h required 1 %h %h",
                 i, beats[i].we, beats[i].addr, beats[i].wdata, lane_addr(32'h1000, 32'd1, i), d[i]);
      end
    end
    if (beats.size() == 16) begin
      n_checks++;
      if (beats[5].cyc - beats[4].cyc != 4) begin
        n_fail++;
        $display("FAIL stall_gap: got %0d cycles required 4", beats[5].cyc - beats[4].cyc);
      end
    end
    n_checks++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL stall_stable: got %0d changes required 0", unstable);
    end
    n_checks++;
    if (wbs.size() != 0 || wb_data !== last_wb) begin
      n_fail++;
      $display("FAIL stall_wbhold: got count %0d data %h required 0 %h", wbs.size(), wb_data, last_wb);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea [4];
    int t;
    ea[0] = 32'hFFFF_FFF8; ea[1] = 32'hFFFF_FFFC; ea[2] = 32'h0; ea[3] = 32'h4;
    launch(1'b0, 5'd4, 32'hFFFF_FFF8, 32'd1, rand_vec(), 4'h0, t);
    wait_done("wrap", 100);
    n_checks++;
    if (beats.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_beats: got %0d required 4", beats.size());
    end
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      n_checks++;
      if (beats[i].addr !== ea[i]) begin
        n_fail++;
        $display("FAIL wrap_addr%0d: got %h required %h", i, beats[i].addr, ea[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t ew;
    int t;
    bit seen = 0;
    rv_lat = 6;
    launch(1'b1, 5'd16, 32'h300, 32'd1, rand_vec(), 4'd7, t);
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (beats.size() >= 8) seen = 1;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pre: got busy %b req %b required 1 0", busy, mem_req);
    end
    rst = 1'b1;
    #1;
    pend = 0;
    rv_lat = 1;
    n_checks++;
    if ({busy, done, wb_we, mem_req, mem_we} !== 5'b0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_out: got ctl %b addr %h required 0 0", {busy, done, wb_we, mem_req, mem_we}, mem_addr);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    n_checks++;
    if (wbs.size() != 0 || dones.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_abort: got wb %0d done %0d required 0 0", wbs.size(), dones.size());
    end
    launch(1'b1, 5'd4, 32'h500, 32'd2, rand_vec(), 4'd2, t);
    wait_done("rstmid_fresh", 100);
    ew = exp_wb(32'h500, 32'd2, 4);
    n_checks++;
    if (wbs.size() != 1 || wbs[0].data !== ew || wbs[0].addr !== 4'd2) begin
      n_fail++;
      $display("FAIL rstmid_fresh: got count %0d data %h required 1 %h",
               wbs.size(), wbs.size() ? wbs[0].data : '0, ew);
    end
    last_wb = ew;
  endtask

  task automatic test_random();
    rand_gnt = 1; rand_lat = 1; noise = 1;
    for (int k = 0; k < 8; k++) begin
      bit          ld = $urandom % 2;
      logic [4:0]  v  = $urandom;
      logic [31:0] b  = $urandom;
      logic [31:0] s  = (k % 2) ? $urandom : $urandom % 8;
      logic [3:0]  dr = $urandom;
      vec_t        d  = rand_vec();
      vec_t        ew;
      int          n  = eff_vl(v);
      int          t;
      mem_key = $urandom;
      launch(ld, v, b, s, d, dr, t);
      wait_done("rand", 1500);
      n_checks++;
      if (beats.size() != n) begin
        n_fail++;
        $display("FAIL rand%0d_beats: got %0d required %0d", k, beats.size(), n);
      end
      for (int i = 0; i < beats.size() && i < n; i++) begin
        n_checks++;
        if (beats[i].we !== !ld || beats[i].addr !== lane_addr(b, s, i) ||
            beats[i].wdata !== (ld ? 32'h0 : d[i])) begin
          n_fail++;
          $display("FAIL rand%0d_beat%0d: got we %b addr %h data %h required %b %h %h",
                   k, i, beats[i].we, beats[i].addr, beats[i].wdata, !ld,
                   lane_addr(b, s, i), ld ? 32'h0 : d[i]);
        end
      end
      ew = exp_wb(b, s, n);
      n_checks++;
      if (ld && (wbs.size() != 1 || wbs[0].data !== ew || wbs[0].addr !== dr)) begin
        n_fail++;
        $display("FAIL rand%0d_wb: got count %0d data %h required 1 %h",
                 k, wbs.size(), wbs.size() ? wbs[0].data : '0, ew);
      end else if (!ld && wbs.size() != 0) begin
        n_fail++;
        $display("FAIL rand%0d_store_wb: got %0d write-backs required 0", k, wbs.size());
      end
      n_checks++;
      if (dones.size() != 1) begin
        n_fail++;
        $display("FAIL rand%0d_done: got %0d pulses required 1", k, dones.size());
      end
      if (ld) last_wb = ew;
    end
    rand_gnt = 0; rand_lat = 0; noise = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_full();
    test_load_full();
    test_load_short();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
